// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// Optional signed-overflow output is enabled by SERIAL_ADD_OVF_EN.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIB_W = 4;

endpackage

// File: rtl/serial_add_ctrl_add_nib.sv
// Combinational 4-bit full-adder slice for the serial adder controller.
// With SERIAL_ADD_OVF_EN it also exposes the carry into bit 3.
module add_nib
    import serial_add_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             c3
`endif
);

    logic [NIB_W:0] sum_d;

    assign sum_d = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, ci};
    assign s     = sum_d[NIB_W-1:0];
    assign co    = sum_d[NIB_W];

`ifdef SERIAL_ADD_OVF_EN
    // Bit-3 sum is a^b^cin, so the carry into bit 3 falls out of it.
    assign c3 = sum_d[NIB_W-1] ^ a[NIB_W-1] ^ b[NIB_W-1];
`endif

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder: one 4-bit slice reused over WIDTH/4 cycles.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   s_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               co_q;
    logic               busy_q;
    logic               done_q;

    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [NIB_W-1:0]   sum_d;
    logic               cout_d;

    assign a_nib = a_q[NIB_W*idx_q +: NIB_W];
    assign b_nib = b_q[NIB_W*idx_q +: NIB_W];

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;
    logic c3_d;
`endif

    add_nib u_nib (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry_q),
        .s  (sum_d),
        .co (cout_d)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .c3 (c3_d)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= ci;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    s_q[NIB_W*idx_q +: NIB_W] <= sum_d;
                    carry_q <= cout_d;
                    if (idx_q == LAST) begin
                        // co/ovf move only here so they hold the old result during RUN
                        co_q    <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_q   <= c3_d ^ cout_d;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: model predicts results and done timing.
// Overflow checks are active when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic             ci    = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic             co;
    logic [WIDTH-1:0] s;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ovf;
        int               done_at;
    } exp_t;

    exp_t             q[$];
    int               cyc     = 0;
    int               free_at = 0;
    int               run_lo  = -10;
    int               run_hi  = -10;
    logic [WIDTH-1:0] prev_s  = '0;
    logic             prev_co = 1'b0;
    logic             prev_ovf = 1'b0;
    int               checks  = 0;
    int               fails   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h",
                     nm, cyc, act, req);
        end
    endtask

    // Reference model: an op is accepted whenever start is seen and the
    // previous op has produced its done; result from plain integer arithmetic.
    initial begin
        exp_t e;
        logic [WIDTH:0] full;
        longint total;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst && start && cyc >= free_at) begin
                full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
                total = longint'($signed(a)) + longint'($signed(b))
                        + longint'(ci);
                e.s   = full[WIDTH-1:0];
                e.co  = full[WIDTH];
                e.ovf = (total > (2**(WIDTH-1)) - 1) ||
                        (total < -(2**(WIDTH-1)));
                e.done_at = cyc + NIB;
                q.push_back(e);
                free_at = cyc + NIB + 1;
                run_lo  = cyc;
                run_hi  = cyc + NIB - 1;
            end
        end
    end

    // Monitor: compares DUT outputs on the falling edge.
    initial begin
        exp_t e;
        logic exp_busy;
        logic exp_done;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_busy = (cyc >= run_lo) && (cyc <= run_hi);
                exp_done = (q.size() > 0) && (q[0].done_at == cyc);
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("done", 32'(done), 32'(exp_done));
                chk("busy_done_excl", 32'(busy & done), 32'(0));
                if (exp_done) begin
                    e = q.pop_front();
                    chk("sum", 32'(s), 32'(e.s));
                    chk("carry_out", 32'(co), 32'(e.co));
`ifdef SERIAL_ADD_OVF_EN
                    chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
                    prev_s   = e.s;
                    prev_co  = e.co;
                    prev_ovf = e.ovf;
                end else if (exp_busy) begin
                    chk("co_hold_run", 32'(co), 32'(prev_co));
`ifdef SERIAL_ADD_OVF_EN
                    chk("ovf_hold_run", 32'(ovf), 32'(prev_ovf));
`endif
                end else begin
                    chk("s_stable", 32'(s), 32'(prev_s));
                    chk("co_stable", 32'(co), 32'(prev_co));
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        start    = 1'b0;
        q.delete();
        free_at  = 0;
        run_lo   = -10;
        run_hi   = -10;
        prev_s   = '0;
        prev_co  = 1'b0;
        prev_ovf = 1'b0;
        #1;
        chk("rst_s", 32'(s), 32'(0));
        chk("rst_co", 32'(co), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'(0));
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic cv);
        int guard;
        guard = 0;
        while (cyc + 1 < free_at && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) chk("op_wait_timeout", 32'(1), 32'(0));
        a     = av;
        b     = bv;
        ci    = cv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        ci    = 1'($urandom);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (q.size() > 0) chk("done_timeout", 32'(q.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();

        op(16'hFFFF, 16'h0001, 1'b0);
        wait_idle();
        chk("t1_s", 32'(s), 32'(16'h0000));
        chk("t1_co", 32'(co), 32'(1));

        op(16'h1234, 16'h4321, 1'b1);
        wait_idle();
        chk("t2_s", 32'(s), 32'(16'h5556));
        chk("t2_co", 32'(co), 32'(0));

`ifdef SERIAL_ADD_OVF_EN
        op(16'h7FFF, 16'h0001, 1'b0);
        wait_idle();
        chk("t3_s", 32'(s), 32'(16'h8000));
        chk("t3_ovf", 32'(ovf), 32'(1));
`endif

        op(16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        #1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        chk("midrun_start_s", 32'(s), 32'(16'h3333));

        op(16'hABCD, 16'h1234, 1'b0);
        @(posedge clk);
        #1;
        do_reset();
        op(16'h0F0F, 16'hF0F0, 1'b1);
        wait_idle();
        chk("post_rst_s", 32'(s), 32'(16'h0000));
        chk("post_rst_co", 32'(co), 32'(1));

        start = 1'b1;
        repeat (16) begin
            a  = WIDTH'($urandom);
            b  = WIDTH'($urandom);
            ci = 1'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_idle();

        repeat (40) begin
            op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 6)) begin
                start = 1'($urandom);
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
                ci    = 1'($urandom);
                @(posedge clk);
                #1;
            end
            start = 1'b0;
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
